// File: rtl/mul_l3_seq_if.sv
// Handshake and data bundle between the level-2 adder rows, the level-3 accumulator
// and the normalise/round consumer. The accumulator connects through the slave modport.
interface mul_l3_seq_if #(
  parameter int PW = 48
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    OUT1234;
  logic [9:0]    OUT5678;
  logic [13:0]   OUT9101112;
  logic [17:0]   OUT13141516;
  logic [21:0]   OUT17181920;
  logic [24:0]   OUT21222324;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  modport master (
    output in_valid, OUT1234, OUT5678, OUT9101112, OUT13141516, OUT17181920, OUT21222324,
    output out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, OUT1234, OUT5678, OUT9101112, OUT13141516, OUT17181920, OUT21222324,
    input  out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul_l3_seq.sv
// Level-3 mantissa multiplier stage: captures six level-2 rows, then adds one offset-weighted
// row per cycle into a PW-bit accumulator through a shared 4-bit-slice CLA adder.
module mul_l3_seq #(
  parameter int PW   = 48,
  parameter int OFS0 = 0,
  parameter int OFS1 = 4,
  parameter int OFS2 = 8,
  parameter int OFS3 = 12,
  parameter int OFS4 = 16,
  parameter int OFS5 = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_l3_seq_if.slave   bus
);
  localparam int NSL = PW / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [2:0]    idx_q;
  logic [PW-1:0] acc_q;
  logic [5:0]    row0_q;
  logic [9:0]    row1_q;
  logic [13:0]   row2_q;
  logic [17:0]   row3_q;
  logic [21:0]   row4_q;
  logic [24:0]   row5_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  logic [PW-1:0] addend_d;
  logic [PW-1:0] sum_d;

  always_comb begin
    addend_d = '0;
    case (idx_q)
      3'd0:    addend_d = PW'(row0_q) << OFS0;
      3'd1:    addend_d = PW'(row1_q) << OFS1;
      3'd2:    addend_d = PW'(row2_q) << OFS2;
      3'd3:    addend_d = PW'(row3_q) << OFS3;
      3'd4:    addend_d = PW'(row4_q) << OFS4;
      3'd5:    addend_d = PW'(row5_q) << OFS5;
      default: addend_d = '0;
    endcase
  end

  // Each slice keeps its own carry-out so the chain never loops through one vector;
  // the top slice has no carry-out because overflow past PW-1 is dropped.
  for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
    logic       cin;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = acc_q[4*gi +: 4] & addend_d[4*gi +: 4];
    assign p = acc_q[4*gi +: 4] ^ addend_d[4*gi +: 4];

    if (gi == 0) begin : g_cin0
      assign cin = 1'b0;
    end else begin : g_cinn
      assign cin = g_slice[gi-1].g_co.cout;
    end

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign sum_d[4*gi +: 4] = p ^ c;

    if (gi < NSL - 1) begin : g_co
      logic cout;
      assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      row0_q      <= '0;
      row1_q      <= '0;
      row2_q      <= '0;
      row3_q      <= '0;
      row4_q      <= '0;
      row5_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            row0_q     <= bus.OUT1234;
            row1_q     <= bus.OUT5678;
            row2_q     <= bus.OUT9101112;
            row3_q     <= bus.OUT13141516;
            row4_q     <= bus.OUT17181920;
            row5_q     <= bus.OUT21222324;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACC;
          end
        end
        ACC: begin
          acc_q <= sum_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd5) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after this edge, so no capture coincides with the handoff
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = acc_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mul_l3_seq.sv
// Bench for the level-3 accumulator: directed rows plus random row sets against a weighted-sum model.
module tb_mul_l3_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_l3_seq_if #(.PW(48)) bus_if ();

  mul_l3_seq #(.PW(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  logic [24:0] rv [6];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of each row (at its own width) times 2^(4*row), kept to 48 bits
  function automatic logic [47:0] ref_sum();
    int          widths [6] = '{6, 10, 14, 18, 22, 25};
    logic [63:0] s = 64'd0;
    logic [63:0] m;
    for (int i = 0; i < 6; i++) begin
      m = (64'd1 << widths[i]) - 64'd1;
      s = s + ((64'(rv[i]) & m) << (4 * i));
    end
    return s[47:0];
  endfunction

  task automatic drive_rows();
    bus_if.OUT1234     = rv[0][5:0];
    bus_if.OUT5678     = rv[1][9:0];
    bus_if.OUT9101112  = rv[2][13:0];
    bus_if.OUT13141516 = rv[3][17:0];
    bus_if.OUT17181920 = rv[4][21:0];
    bus_if.OUT21222324 = rv[5];
  endtask

  task automatic junk_rows();
    bus_if.OUT1234     = 6'($urandom);
    bus_if.OUT5678     = 10'($urandom);
    bus_if.OUT9101112  = 14'($urandom);
    bus_if.OUT13141516 = 18'($urandom);
    bus_if.OUT17181920 = 22'($urandom);
    bus_if.OUT21222324 = 25'($urandom);
  endtask

  task automatic set_rows(input logic [24:0] r0, r1, r2, r3, r4, r5);
    rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3; rv[4] = r4; rv[5] = r5;
  endtask

  task automatic random_rows();
    for (int i = 0; i < 6; i++) rv[i] = 25'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [47:0] want, input int hold);
    int n;
    @(negedge clk);
    drive_rows();
    bus_if.in_valid = 1'b1;
    n = 0;
    while (!bus_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 64'(bus_if.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    junk_rows();
    check({tag, "_busy"}, {62'd0, bus_if.busy, bus_if.in_ready}, 64'd2);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_if.out_valid && n < 20);
    check({tag, "_latency"}, 64'(n), 64'd6);
    check({tag, "_product"}, 64'(bus_if.product), 64'(want));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      junk_rows();
      bus_if.in_valid = 1'b1;
      check({tag, "_hold_product"}, 64'(bus_if.product), 64'(want));
      check({tag, "_hold_flags"}, {61'd0, bus_if.out_valid, bus_if.in_ready, bus_if.busy}, 64'd4);
    end
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b0;
    check({tag, "_handoff"}, {61'd0, bus_if.out_valid, bus_if.in_ready, bus_if.busy}, 64'd2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    set_rows(0, 0, 0, 0, 0, 0);
    drive_rows();
    repeat (3) @(negedge clk);
    check("reset_flags", {61'd0, bus_if.out_valid, bus_if.in_ready, bus_if.busy}, 64'd2);
    check("reset_product", 64'(bus_if.product), 64'd0);
    rst_n = 1'b1;

    repeat (4) @(negedge clk);
    check("idle_hold", {61'd0, bus_if.out_valid, bus_if.in_ready, bus_if.busy}, 64'd2);

    set_rows(0, 0, 0, 0, 0, 0);           run_op("zero", 48'h0, 0);
    set_rows(25'h3F, 0, 0, 0, 0, 0);      run_op("row0_max", 48'h3F, 0);
    set_rows(0, 1, 0, 0, 0, 0);           run_op("row1_one", 48'h10, 0);
    set_rows(0, 0, 0, 0, 0, 25'h1FFFFFF); run_op("row5_max", 48'h1FFFFFF00000, 0);
    set_rows(1, 1, 1, 1, 1, 1);           run_op("all_one", 48'h111111, 0);
    random_rows();                        run_op("stall3", ref_sum(), 3);

    // Reset pulsed in the middle of accumulation
    random_rows();
    @(negedge clk);
    drive_rows();
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_flags", {61'd0, bus_if.out_valid, bus_if.in_ready, bus_if.busy}, 64'd2);
    check("midreset_product", 64'(bus_if.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_rows(0, 0, 1, 0, 0, 0);           run_op("after_reset", 48'h100, 0);

    for (int t = 0; t < 100; t++) begin
      random_rows();
      run_op($sformatf("rand%0d", t), ref_sum(), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
